wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter p_TOUT, default 255, WB ack timeout in clock cycles (1..65535).
REQ-002 Parameter p_AW, default 32, WB address width.
REQ-003 i_clk  input  1  system clock; the block uses one clock only.
REQ-004 i_arst_n  input  1  reset, asynchronous, active-low.
REQ-005 iv_rx_dat  input  8  command byte from the UART RX path.
REQ-006 i_rx_vld  input  1  iv_rx_dat is valid.
REQ-007 o_rx_rdy  output  1  block accepts a byte; a transfer occurs when i_rx_vld and o_rx_rdy are both 1.
REQ-008 ov_tx_dat  output  8  reply byte to the UART TX path.
REQ-009 o_tx_vld  output  1  ov_tx_dat is valid.
REQ-010 i_tx_rdy  input  1  sink accepts a byte; a transfer occurs when o_tx_vld and i_tx_rdy are both 1.
REQ-011 ov_wbm_adr  output  p_AW  WB byte address.
REQ-012 ov_wbm_dat  output  32  WB write data.
REQ-013 iv_wbm_dat  input  32  WB read data.
REQ-014 o_wbm_we, o_wbm_stb, o_wbm_cyc  output  1 each  WB write enable, strobe and cycle.
REQ-015 ov_wbm_sel  output  4  WB byte select; driven to 4'hF during every cycle.
REQ-016 i_wbm_ack  input  1  WB acknowledge.

Function
REQ-017 Frame formats, multi-byte fields MSB first:
- Write: 'W'(0x57) + addr[4] + data[4].
- Read: 'R'(0x52) + addr[4].
REQ-018 FSM states: IDLE, ADDR, DATA, WB, RESP.
REQ-019 IDLE:
- 'W' or 'R' -> ADDR.
- Any other byte -> RESP with reply 'E'(0x45).
REQ-020 ADDR collects 4 bytes, shifted into the address register. After the 4th byte: write -> DATA; read -> WB.
REQ-021 DATA collects 4 bytes into the write-data register, then -> WB.
REQ-022 o_rx_rdy = 1 only in IDLE, ADDR and DATA.
REQ-023 WB state:
- o_wbm_cyc = o_wbm_stb = 1; o_wbm_we = 1 for a write.
- Address and data are held stable until the cycle ends.
REQ-024 The WB cycle ends on the first clock edge where i_wbm_ack = 1.
- cyc and stb deassert in the next cycle.
- Read data is captured on that same edge.
REQ-025 First-cycle ack: if ack is 1 in the first WB cycle, the WB phase lasts exactly 1 cycle.
REQ-026 Timeout:
- A 16-bit counter increments each WB cycle and is cleared on entry to WB.
- If the count reaches p_TOUT without ack, the cycle is terminated and the FSM goes to RESP with reply 'T'(0x54).
- An ack arriving in the same cycle as the timeout wins.
REQ-027 Replies:
- Write ok: 'K'(0x4B).
- Read ok: 'D'(0x44) followed by the 4 data bytes, MSB first (5 bytes total).
REQ-028 RESP state:
- o_tx_vld = 1; ov_tx_dat is held until i_tx_rdy.
- The byte index advances per accepted byte.
- After the last byte -> IDLE.
REQ-029 Back-pressure (i_tx_rdy = 0) stalls RESP indefinitely; no RX bytes are accepted meanwhile.
REQ-030 Outputs are registered; no combinational path from any input to any output except none (fully registered).

Reset
REQ-031 On i_arst_n = 0, all of the following apply immediately and asynchronously:
- FSM -> IDLE.
- o_wbm_cyc, o_wbm_stb, o_wbm_we = 0; ov_wbm_adr, ov_wbm_dat = 0; ov_wbm_sel = 0.
- o_tx_vld = 0; ov_tx_dat = 0; o_rx_rdy = 0; counters = 0.
REQ-032 o_rx_rdy rises in the first clock cycle after reset release.
REQ-033 A reset during a WB cycle drops cyc/stb at once. The partial frame is discarded and no reply is sent.

Structure
REQ-034 A shared package wb_cmd_pkg holds:
- the state enum;
- opcode and reply byte constants ('W', 'R', 'K', 'D', 'E', 'T');
- the default timeout.
REQ-035 One module only; no sub-modules are required.
REQ-036 The block connects directly to an existing simple WB cross as a second-direction master.

Verification
REQ-037 Write frame 57 00 01 00 04 00 00 00 A5, ack after 2 cycles -> one WB cycle with adr=0x00010004, dat=0x000000A5, we=1, sel=F; reply 4B.
REQ-038 Read frame 52 00 01 10 00, ack in the 1st cycle with dat=0xDEADBEEF -> 1-cycle WB phase; reply 44 DE AD BE EF.
REQ-039 Read frame with no ack, p_TOUT=8 -> cyc high exactly 8 cycles, then deasserted; reply 54.
REQ-040 Byte 0x41 in IDLE -> no WB cycle; reply 45; the next valid frame is processed normally.
REQ-041 Read reply with i_tx_rdy toggled 1/0 every cycle -> 5 bytes delivered in order, none lost or duplicated; o_rx_rdy = 0 throughout.
REQ-042 Assert i_arst_n = 0 mid WB cycle -> cyc/stb = 0 in the same cycle; no reply; a fresh write frame after release succeeds.

Source files
------------

// File: rtl/wb_cmd_pkg.sv
// Shared types and byte constants for the UART-command Wishbone master.
package wb_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WB,
        ST_RESP
    } state_t;

    localparam logic [7:0] OP_WR    = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD    = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_DAT  = 8'h44;  // 'D'
    localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'
    localparam logic [7:0] RSP_TOUT = 8'h54;  // 'T'

    localparam int TOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_cmd_master.sv
// Purpose: parses W/R byte frames from a UART RX stream, runs one Wishbone cycle, replies on TX.
// Latency: WB cycle starts one clock after the last frame byte; reply starts one clock after ack/timeout.
// Backpressure: RX is ready only while collecting a frame; a stalled TX sink holds the reply indefinitely.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int p_TOUT = TOUT_DEFAULT,
    parameter int p_AW   = 32
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic [7:0]      iv_rx_dat,
    input  logic            i_rx_vld,
    output logic            o_rx_rdy,
    output logic [7:0]      ov_tx_dat,
    output logic            o_tx_vld,
    input  logic            i_tx_rdy,
    output logic [p_AW-1:0] ov_wbm_adr,
    output logic [31:0]     ov_wbm_dat,
    input  logic [31:0]     iv_wbm_dat,
    output logic            o_wbm_we,
    output logic            o_wbm_stb,
    output logic            o_wbm_cyc,
    output logic [3:0]      ov_wbm_sel,
    input  logic            i_wbm_ack
);

    state_t          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [15:0]     tout_cnt_q, tout_cnt_d;
    logic [p_AW-1:0] adr_q, adr_d;
    logic [31:0]     wdat_q, wdat_d;
    logic            wr_q, wr_d;
    // Reply shift register: the byte on the TX port is always the top byte.
    logic [39:0]     resp_q, resp_d;
    logic [2:0]      rem_q, rem_d;
    logic            rx_rdy_q, rx_rdy_d;
    logic            tx_vld_q, tx_vld_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;

    logic rx_fire;
    logic tx_fire;

    assign rx_fire = i_rx_vld & rx_rdy_q;
    assign tx_fire = tx_vld_q & i_tx_rdy;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tout_cnt_d = tout_cnt_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        wr_d       = wr_q;
        resp_d     = resp_q;
        rem_d      = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (iv_rx_dat == OP_WR || iv_rx_dat == OP_RD) begin
                        state_d    = ST_ADDR;
                        wr_d       = (iv_rx_dat == OP_WR);
                        byte_cnt_d = 2'd0;
                        adr_d      = '0;
                    end else begin
                        state_d = ST_RESP;
                        resp_d  = {RSP_ERR, 32'h0};
                        rem_d   = 3'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    adr_d      = {adr_q[p_AW-9:0], iv_rx_dat};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = wr_q ? ST_DATA : ST_WB;
                        tout_cnt_d = 16'd0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_fire) begin
                    wdat_d     = {wdat_q[23:0], iv_rx_dat};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = ST_WB;
                        tout_cnt_d = 16'd0;
                    end
                end
            end
            ST_WB: begin
                tout_cnt_d = tout_cnt_q + 16'd1;
                // Ack is tested first so it wins over a coincident timeout.
                if (i_wbm_ack) begin
                    state_d = ST_RESP;
                    if (wr_q) begin
                        resp_d = {RSP_OK, 32'h0};
                        rem_d  = 3'd1;
                    end else begin
                        resp_d = {RSP_DAT, iv_wbm_dat};
                        rem_d  = 3'd5;
                    end
                end else if (tout_cnt_d == 16'(p_TOUT)) begin
                    state_d = ST_RESP;
                    resp_d  = {RSP_TOUT, 32'h0};
                    rem_d   = 3'd1;
                end
            end
            ST_RESP: begin
                if (tx_fire) begin
                    resp_d = {resp_q[31:0], 8'h0};
                    rem_d  = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rx_rdy_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
        tx_vld_d = (state_d == ST_RESP);
        cyc_d    = (state_d == ST_WB);
        we_d     = cyc_d & wr_d;
        sel_d    = cyc_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            tout_cnt_q <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            wr_q       <= 1'b0;
            resp_q     <= '0;
            rem_q      <= '0;
            rx_rdy_q   <= 1'b0;
            tx_vld_q   <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tout_cnt_q <= tout_cnt_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            wr_q       <= wr_d;
            resp_q     <= resp_d;
            rem_q      <= rem_d;
            rx_rdy_q   <= rx_rdy_d;
            tx_vld_q   <= tx_vld_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
        end
    end

    assign o_rx_rdy   = rx_rdy_q;
    assign o_tx_vld   = tx_vld_q;
    assign ov_tx_dat  = resp_q[39:32];
    assign o_wbm_cyc  = cyc_q;
    assign o_wbm_stb  = cyc_q;
    assign o_wbm_we   = we_q;
    assign ov_wbm_sel = sel_q;
    assign ov_wbm_adr = adr_q;
    assign ov_wbm_dat = wdat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench: frames are driven byte by byte, expected WB cycles and reply bytes are queued,
// and independent monitors compare what the DUT presents on the WB and TX sides.
module tb_wb_cmd_master;

    localparam int TOUT = 8;

    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic [7:0]  iv_rx_dat = 8'h00;
    logic        i_rx_vld = 1'b0;
    logic        o_rx_rdy;
    logic [7:0]  ov_tx_dat;
    logic        o_tx_vld;
    logic        i_tx_rdy = 1'b1;
    logic [31:0] ov_wbm_adr;
    logic [31:0] ov_wbm_dat;
    logic [31:0] iv_wbm_dat = 32'h0;
    logic        o_wbm_we;
    logic        o_wbm_stb;
    logic        o_wbm_cyc;
    logic [3:0]  ov_wbm_sel;
    logic        i_wbm_ack = 1'b0;

    wb_cmd_master #(.p_TOUT(TOUT), .p_AW(32)) dut (
        .i_clk      (i_clk),
        .i_arst_n   (i_arst_n),
        .iv_rx_dat  (iv_rx_dat),
        .i_rx_vld   (i_rx_vld),
        .o_rx_rdy   (o_rx_rdy),
        .ov_tx_dat  (ov_tx_dat),
        .o_tx_vld   (o_tx_vld),
        .i_tx_rdy   (i_tx_rdy),
        .ov_wbm_adr (ov_wbm_adr),
        .ov_wbm_dat (ov_wbm_dat),
        .iv_wbm_dat (iv_wbm_dat),
        .o_wbm_we   (o_wbm_we),
        .o_wbm_stb  (o_wbm_stb),
        .o_wbm_cyc  (o_wbm_cyc),
        .ov_wbm_sel (ov_wbm_sel),
        .i_wbm_ack  (i_wbm_ack)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } wb_exp_t;

    wb_exp_t    exp_wb[$];
    int         exp_len[$];
    logic [7:0] exp_tx[$];

    int n_chk  = 0;
    int n_fail = 0;
    int ack_dly = -1;   // ack in cycle ack_dly+1 of the WB phase; negative = never
    bit tog_rdy = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // WB slave + monitor: checks cycle contents on its first cycle and its length when it ends.
    initial begin
        int cyc_cnt = 0;
        wb_exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_wbm_cyc) begin
                cyc_cnt++;
                if (cyc_cnt == 1) begin
                    if (exp_wb.size() == 0) begin
                        chk("wb_unexpected_cycle", 64'd1, 64'd0);
                    end else begin
                        e = exp_wb.pop_front();
                        chk("wb_adr", 64'(ov_wbm_adr), 64'(e.adr));
                        chk("wb_we",  64'(o_wbm_we),   64'(e.we));
                        chk("wb_stb", 64'(o_wbm_stb),  64'd1);
                        chk("wb_sel", 64'(ov_wbm_sel), 64'hF);
                        if (e.we) chk("wb_dat", 64'(ov_wbm_dat), 64'(e.dat));
                    end
                end else begin
                    chk("wb_adr_stable", 64'(ov_wbm_adr), 64'(e.adr));
                end
                i_wbm_ack = (ack_dly >= 0) && (cyc_cnt == ack_dly + 1);
            end else begin
                if (cyc_cnt != 0 && i_arst_n) begin
                    if (exp_len.size() == 0) chk("wb_len_unexpected", 64'(cyc_cnt), 64'd0);
                    else chk("wb_cyc_len", 64'(cyc_cnt), 64'(exp_len.pop_front()));
                end
                cyc_cnt   = 0;
                i_wbm_ack = 1'b0;
            end
        end
    end

    // TX monitor: each accepted reply byte is compared against the queue head.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_tx_vld) chk("rx_rdy_in_resp", 64'(o_rx_rdy), 64'd0);
            if (o_tx_vld && i_tx_rdy) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 64'(ov_tx_dat), 64'hFFFF);
                else chk("tx_byte", 64'(ov_tx_dat), 64'(exp_tx.pop_front()));
            end
        end
    end

    // TX sink ready: steady high, or toggling every cycle.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_rdy = tog_rdy ? ~i_tx_rdy : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        i_rx_vld  = 1'b1;
        iv_rx_dat = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_rx_rdy) begin
                @(posedge i_clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rx_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input logic [71:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[(n-1-i)*8 +: 8]);
        i_rx_vld = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (exp_tx.size() == 0 && exp_len.size() == 0 && !o_tx_vld && !o_wbm_cyc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_rx_rdy", 64'(o_rx_rdy),   64'd0);
        chk("rst_tx_vld", 64'(o_tx_vld),   64'd0);
        chk("rst_tx_dat", 64'(ov_tx_dat),  64'd0);
        chk("rst_cyc",    64'(o_wbm_cyc),  64'd0);
        chk("rst_stb",    64'(o_wbm_stb),  64'd0);
        chk("rst_we",     64'(o_wbm_we),   64'd0);
        chk("rst_sel",    64'(ov_wbm_sel), 64'd0);
        chk("rst_adr",    64'(ov_wbm_adr), 64'd0);
        chk("rst_dat",    64'(ov_wbm_dat), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_reset_outputs();
        repeat (3) @(posedge i_clk);
        #1;
        i_arst_n = 1'b1;
        chk("rx_rdy_at_release", 64'(o_rx_rdy), 64'd0);
        @(posedge i_clk);
        #1;
        chk("rx_rdy_after_release", 64'(o_rx_rdy), 64'd1);

        // Write, ack in 3rd cycle.
        ack_dly = 2;
        exp_wb.push_back('{adr: 32'h00010004, dat: 32'h000000A5, we: 1'b1});
        exp_len.push_back(3);
        exp_tx.push_back(8'h4B);
        send_frame(72'h57_00010004_000000A5, 9);
        wait_drain();

        // Read, first-cycle ack.
        ack_dly = 0;
        iv_wbm_dat = 32'hDEADBEEF;
        exp_wb.push_back('{adr: 32'h00011000, dat: 32'h0, we: 1'b0});
        exp_len.push_back(1);
        exp_tx.push_back(8'h44); exp_tx.push_back(8'hDE); exp_tx.push_back(8'hAD);
        exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
        send_frame(72'h52_00011000, 5);
        wait_drain();

        // Read with no ack: timeout after TOUT cycles.
        ack_dly = -1;
        exp_wb.push_back('{adr: 32'h00000040, dat: 32'h0, we: 1'b0});
        exp_len.push_back(TOUT);
        exp_tx.push_back(8'h54);
        send_frame(72'h52_00000040, 5);
        wait_drain();

        // Unknown opcode, then a normal write.
        exp_tx.push_back(8'h45);
        send_frame(72'h41, 1);
        wait_drain();
        ack_dly = 1;
        exp_wb.push_back('{adr: 32'h12345678, dat: 32'h9ABCDEF0, we: 1'b1});
        exp_len.push_back(2);
        exp_tx.push_back(8'h4B);
        send_frame(72'h57_12345678_9ABCDEF0, 9);
        wait_drain();

        // Read reply under toggling TX ready.
        ack_dly = 1;
        iv_wbm_dat = 32'h12345678;
        tog_rdy = 1'b1;
        exp_wb.push_back('{adr: 32'hA0B0C0D0, dat: 32'h0, we: 1'b0});
        exp_len.push_back(2);
        exp_tx.push_back(8'h44); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
        send_frame(72'h52_A0B0C0D0, 5);
        wait_drain();
        tog_rdy = 1'b0;

        // Reset in the middle of a WB cycle: no reply expected.
        ack_dly = -1;
        exp_wb.push_back('{adr: 32'h0000BEEF, dat: 32'h11111111, we: 1'b1});
        send_frame(72'h57_0000BEEF_11111111, 9);
        chk("wb_cyc_before_reset", 64'(o_wbm_cyc), 64'd1);
        @(posedge i_clk);
        #1;
        i_arst_n = 1'b0;
        #1;
        chk("reset_cyc_drop", 64'(o_wbm_cyc), 64'd0);
        chk("reset_stb_drop", 64'(o_wbm_stb), 64'd0);
        chk("reset_tx_vld",   64'(o_tx_vld),  64'd0);
        repeat (3) @(posedge i_clk);
        #1;
        i_arst_n = 1'b1;
        repeat (20) @(posedge i_clk);
        #1;
        chk("no_reply_after_reset", 64'(exp_tx.size()), 64'd0);

        ack_dly = 1;
        exp_wb.push_back('{adr: 32'h00000010, dat: 32'hCAFEF00D, we: 1'b1});
        exp_len.push_back(2);
        exp_tx.push_back(8'h4B);
        send_frame(72'h57_00000010_CAFEF00D, 9);
        wait_drain();

        chk("wb_queue_empty", 64'(exp_wb.size()), 64'd0);
        chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
